// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational execute-stage ALU between two requesters using
//   round-robin arbitration. Owns the architectural NZCV register, feeds its
//   C bit to the ALU carry-in, and writes it from the ALU flags when the
//   request carries S=1. One operation takes IDLE -> EXEC -> RESP.
//
// Ports
//   clk, rstN                     clock (rising edge), async active-low reset
//   req{0,1}ValidIn/ReadyOut      request handshake
//   req{0,1}Val1In/Val2In         operands
//   req{0,1}CmdIn, req{0,1}SIn    ALU command, status-update enable
//   resp{0,1}ValidOut/ReadyIn     response handshake (only the owner is valid)
//   respResOut, respStatusOut     shared response result and flags {N,Z,C,V}
//   aluVal1Out/aluVal2Out/aluCmdOut/aluCarryOut   to the ALU
//   aluResIn, aluStatusIn         from the ALU (combinational)
//   statusRegOut                  architectural NZCV register
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         req0ValidIn,
  output logic         req0ReadyOut,
  input  logic [N-1:0] req0Val1In,
  input  logic [N-1:0] req0Val2In,
  input  logic [3:0]   req0CmdIn,
  input  logic         req0SIn,
  input  logic         req1ValidIn,
  output logic         req1ReadyOut,
  input  logic [N-1:0] req1Val1In,
  input  logic [N-1:0] req1Val2In,
  input  logic [3:0]   req1CmdIn,
  input  logic         req1SIn,
  output logic         resp0ValidOut,
  input  logic         resp0ReadyIn,
  output logic         resp1ValidOut,
  input  logic         resp1ReadyIn,
  output logic [N-1:0] respResOut,
  output logic [3:0]   respStatusOut,
  output logic [N-1:0] aluVal1Out,
  output logic [N-1:0] aluVal2Out,
  output logic [3:0]   aluCmdOut,
  output logic         aluCarryOut,
  input  logic [N-1:0] aluResIn,
  input  logic [3:0]   aluStatusIn,
  output logic [3:0]   statusRegOut
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic         s_q, s_d;
  logic [N-1:0] val1_q, val1_d;
  logic [N-1:0] val2_q, val2_d;
  logic [3:0]   cmd_q, cmd_d;
  logic [N-1:0] res_q, res_d;
  logic [3:0]   rstat_q, rstat_d;
  logic [3:0]   status_q, status_d;

  logic grant_sel;  // 0 = req0, 1 = req1
  logic req_hs;
  logic resp_hs;

  // Round-robin: on contention the requester that did not win last time
  // goes first; otherwise whichever one is valid.
  always_comb begin
    if (req0ValidIn && req1ValidIn) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req1ValidIn;
    end
  end

  assign req0ReadyOut  = (state_q == IDLE) && req0ValidIn && !grant_sel;
  assign req1ReadyOut  = (state_q == IDLE) && req1ValidIn &&  grant_sel;
  assign req_hs        = req0ReadyOut || req1ReadyOut;

  assign resp0ValidOut = (state_q == RESP) && !owner_q;
  assign resp1ValidOut = (state_q == RESP) &&  owner_q;
  // Only the owner's ready can complete the response.
  assign resp_hs       = (resp0ValidOut && resp0ReadyIn) ||
                         (resp1ValidOut && resp1ReadyIn);

  // ALU is fed straight from the operand registers, so it keeps showing the
  // last operation while idle. Carry-in is the pre-update C bit.
  assign aluVal1Out    = val1_q;
  assign aluVal2Out    = val2_q;
  assign aluCmdOut     = cmd_q;
  assign aluCarryOut   = status_q[1];

  assign respResOut    = res_q;
  assign respStatusOut = rstat_q;
  assign statusRegOut  = status_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    s_d          = s_q;
    val1_d       = val1_q;
    val2_d       = val2_q;
    cmd_d        = cmd_q;
    res_d        = res_q;
    rstat_d      = rstat_q;
    status_d     = status_q;

    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          owner_d = grant_sel;
          val1_d  = grant_sel ? req1Val1In : req0Val1In;
          val2_d  = grant_sel ? req1Val2In : req0Val2In;
          cmd_d   = grant_sel ? req1CmdIn  : req0CmdIn;
          s_d     = grant_sel ? req1SIn    : req0SIn;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = aluResIn;
        rstat_d = aluStatusIn;
        if (s_q) begin
          status_d = aluStatusIn;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // req0 wins the first contention
      owner_q      <= 1'b0;
      s_q          <= 1'b0;
      val1_q       <= '0;
      val2_q       <= '0;
      cmd_q        <= '0;
      res_q        <= '0;
      rstat_q      <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      s_q          <= s_d;
      val1_q       <= val1_d;
      val2_q       <= val2_d;
      cmd_q        <= cmd_d;
      res_q        <= res_d;
      rstat_q      <= rstat_d;
      status_q     <= status_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter. A behavioural ALU answers the arbiter's ALU port;
//   expected responses are pushed to a scoreboard queue at request acceptance
//   and popped at the response handshake.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_s;
  logic [31:0] req0_v1, req0_v2;
  logic [3:0]  req0_cmd;
  logic        req1_valid, req1_ready, req1_s;
  logic [31:0] req1_v1, req1_v2;
  logic [3:0]  req1_cmd;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_res;
  logic [3:0]  resp_status;
  logic [31:0] alu_val1, alu_val2, alu_res;
  logic [3:0]  alu_cmd, alu_status, status_reg;
  logic        alu_carry;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(32)) dut (
    .clk          (clk),
    .rstN         (rst_n),
    .req0ValidIn  (req0_valid),
    .req0ReadyOut (req0_ready),
    .req0Val1In   (req0_v1),
    .req0Val2In   (req0_v2),
    .req0CmdIn    (req0_cmd),
    .req0SIn      (req0_s),
    .req1ValidIn  (req1_valid),
    .req1ReadyOut (req1_ready),
    .req1Val1In   (req1_v1),
    .req1Val2In   (req1_v2),
    .req1CmdIn    (req1_cmd),
    .req1SIn      (req1_s),
    .resp0ValidOut(resp0_valid),
    .resp0ReadyIn (resp0_ready),
    .resp1ValidOut(resp1_valid),
    .resp1ReadyIn (resp1_ready),
    .respResOut   (resp_res),
    .respStatusOut(resp_status),
    .aluVal1Out   (alu_val1),
    .aluVal2Out   (alu_val2),
    .aluCmdOut    (alu_cmd),
    .aluCarryOut  (alu_carry),
    .aluResIn     (alu_res),
    .aluStatusIn  (alu_status),
    .statusRegOut (status_reg)
  );

  // Behavioural ALU, ARM-style flags {N,Z,C,V}; C is "no borrow" on subtract.
  // Logic/move ops pass C through and clear V. Unknown commands return 0.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] cmd, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = cin; v = 1'b0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        w = {1'b0, a} + {1'b0, b} + ((cmd == 4'b0011) ? {32'b0, cin} : 33'd0);
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0100, 4'b0101: begin
        w = {1'b0, a} + {1'b0, ~b} + ((cmd == 4'b0100) ? 33'd1 : {32'b0, cin});
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      default: begin r = '0; c = 1'b0; end
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_status, alu_res} = alu_f(alu_val1, alu_val2, alu_cmd, alu_carry);

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic [3:0]  stat;
  } exp_t;

  typedef struct {
    int          r;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  cmd;
    logic        s;
    logic [31:0] eres;
    logic [3:0]  estat;
    int          hold;
  } vec_t;

  exp_t       sb_q[$];
  logic [3:0] sreg_model;
  vec_t       vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic logic rdy(input int r);
    return (r == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rvalid(input int r);
    return (r == 0) ? resp0_valid : resp1_valid;
  endfunction

  task automatic set_req(input int r, input logic v, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [3:0] cmd, input logic s);
    if (r == 0) begin
      req0_valid = v; req0_v1 = v1; req0_v2 = v2; req0_cmd = cmd; req0_s = s;
    end else begin
      req1_valid = v; req1_v1 = v1; req1_v2 = v2; req1_cmd = cmd; req1_s = s;
    end
  endtask

  task automatic set_resp_ready(input int r, input logic v);
    if (r == 0) resp0_ready = v;
    else        resp1_ready = v;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_owner_valid"}, 32'(rvalid(e.owner)), 32'd1);
    chk({tag, "_res"}, resp_res, e.res);
    chk({tag, "_stat"}, 32'(resp_status), 32'(e.stat));
    $display("txn %s owner=%0d res=0x%08h stat=%b sreg=%b", tag, e.owner, resp_res,
             resp_status, status_reg);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, '0, 1'b0);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    sb_q.delete();
    sreg_model = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One operation from requester r. Entered and left just after a rising edge.
  // With hold>0 the owner withholds respReady for that many RESP cycles while
  // the other requester asserts request valid and respReady.
  task automatic do_op(input string tag, input int r, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [3:0] cmd, input logic s,
                       input logic [31:0] eres, input logic [3:0] estat, input int hold);
    int   waited;
    bit   got;
    logic exp_c;
    exp_t e;
    waited = 0; got = 0;
    set_req(r, 1'b1, v1, v2, cmd, s);
    while (!got && waited < 20) begin
      @(negedge clk);
      if (rdy(r)) got = 1;
      else waited++;
    end
    chk({tag, "_accept_wait"}, 32'(waited), 32'd0);
    if (!got) begin
      set_req(r, 1'b0, '0, '0, '0, 1'b0);
      return;
    end
    chk({tag, "_other_ready"}, 32'(rdy(1 - r)), 32'd0);
    e.owner = r; e.res = eres; e.stat = estat;
    sb_q.push_back(e);
    exp_c = sreg_model[1];
    if (s) sreg_model = estat;

    @(posedge clk); #1;
    set_req(r, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);  // EXEC
    chk({tag, "_alu_v1"}, alu_val1, v1);
    chk({tag, "_alu_v2"}, alu_val2, v2);
    chk({tag, "_alu_cmd"}, 32'(alu_cmd), 32'(cmd));
    chk({tag, "_alu_cin"}, 32'(alu_carry), 32'(exp_c));
    chk({tag, "_exec_rdy"}, 32'({req0_ready, req1_ready, resp0_valid, resp1_valid}), 32'd0);

    @(posedge clk); #1;
    if (hold > 0) begin
      set_req(1 - r, 1'b1, 32'h55, 32'h66, 4'b0010, 1'b1);
      set_resp_ready(1 - r, 1'b1);
    end
    @(negedge clk);  // RESP, T+2
    chk({tag, "_resp_valid"}, 32'(rvalid(r)), 32'd1);
    chk({tag, "_resp_other"}, 32'(rvalid(1 - r)), 32'd0);
    chk({tag, "_sreg"}, 32'(status_reg), 32'(sreg_model));
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("%s_hold%0d_res", tag, h), resp_res, eres);
      chk($sformatf("%s_hold%0d_valid", tag, h), 32'({rvalid(r), rvalid(1 - r)}), 32'b10);
      chk($sformatf("%s_hold%0d_rdy", tag, h), 32'({req0_ready, req1_ready}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    set_resp_ready(r, 1'b1);
    #1;
    if (hold > 0) chk({tag, "_hs_rdy"}, 32'({req0_ready, req1_ready}), 32'd0);
    pop_check(tag);
    @(posedge clk); #1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    if (hold > 0) set_req(1 - r, 1'b0, '0, '0, '0, 1'b0);
    chk({tag, "_idle_valid"}, 32'({resp0_valid, resp1_valid}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int   waited;
  int   g;
  int   idx0, idx1;
  exp_t e;

  initial begin
    //            r  v1            v2            cmd      s     eres          estat  hold
    vecs[0]  = '{0, 32'h7FFFFFFF, 32'h00000001, 4'b0010, 1'b1, 32'h80000000, 4'b1001, 0};
    vecs[1]  = '{1, 32'hFFFFFFFF, 32'h00000001, 4'b0010, 1'b1, 32'h00000000, 4'b0110, 0};
    vecs[2]  = '{1, 32'h00000002, 32'h00000003, 4'b0011, 1'b0, 32'h00000006, 4'b0000, 0};
    vecs[3]  = '{0, 32'h00000005, 32'h00000007, 4'b0100, 1'b0, 32'hFFFFFFFE, 4'b1000, 5};
    vecs[4]  = '{0, 32'h0000000A, 32'h00000003, 4'b0101, 1'b1, 32'h00000007, 4'b0010, 0};
    vecs[5]  = '{1, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0110, 1'b1, 32'hF000F000, 4'b1010, 0};
    vecs[6]  = '{0, 32'hAAAAAAAA, 32'hAAAAAAAA, 4'b1000, 1'b1, 32'h00000000, 4'b0110, 0};
    vecs[7]  = '{1, 32'h13572468, 32'h00000000, 4'b1001, 1'b0, 32'hFFFFFFFF, 4'b1010, 0};
    vecs[8]  = '{0, 32'hDEADBEEF, 32'h12345678, 4'b0001, 1'b0, 32'h12345678, 4'b0010, 0};
    vecs[9]  = '{1, 32'h00000001, 32'h00000002, 4'b0111, 1'b1, 32'h00000003, 4'b0010, 0};
    vecs[10] = '{0, 32'h11111111, 32'h22222222, 4'b1111, 1'b1, 32'h00000000, 4'b0100, 0};
    vecs[11] = '{1, 32'h00000005, 32'h00000005, 4'b0101, 1'b1, 32'hFFFFFFFF, 4'b1000, 0};

    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_resp_valid", 32'({resp0_valid, resp1_valid}), 32'd0);
    chk("rst_sreg", 32'(status_reg), 32'd0);
    chk("rst_res", resp_res, 32'd0);
    chk("rst_stat", 32'(resp_status), 32'd0);
    chk("rst_alu_v1", alu_val1, 32'd0);
    chk("rst_alu_v2", alu_val2, 32'd0);
    chk("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    @(posedge clk); #1;

    // Table-driven single-requester operations.
    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("row%0d", i), vecs[i].r, vecs[i].v1, vecs[i].v2, vecs[i].cmd,
            vecs[i].s, vecs[i].eres, vecs[i].estat, vecs[i].hold);
    end

    // Reset during EXEC of an S=1 op: no response, no status update.
    set_req(0, 1'b1, 32'h7FFFFFFF, 32'h1, 4'b0010, 1'b1);
    waited = 0;
    while (!req0_ready && waited < 20) begin
      @(negedge clk);
      if (!req0_ready) waited++;
    end
    chk("mid_rst_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    sreg_model = 4'b0000;
    #2;
    chk("mid_rst_sreg", 32'(status_reg), 32'd0);
    chk("mid_rst_valid", 32'({resp0_valid, resp1_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_quiet%0d", k), 32'({resp0_valid, resp1_valid, status_reg}), 32'd0);
    end
    @(posedge clk); #1;
    do_op("post_rst", 1, 32'hFFFFFFFF, 32'h1, 4'b0010, 1'b1, 32'h0, 4'b0110, 0);

    // Contention from reset: both always valid, grants must alternate 0,1,0,1.
    do_reset();
    idx0 = 0; idx1 = 0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    set_req(0, 1'b1, 32'h100, 32'h1, 4'b0010, 1'b0);
    set_req(1, 1'b1, 32'h200, 32'h1, 4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      waited = 0; g = -1;
      while (g < 0 && waited < 20) begin
        @(negedge clk);
        if (req0_ready) g = 0;
        else if (req1_ready) g = 1;
        else waited++;
      end
      if (g < 0) begin
        chk("cont_grant_timeout", 32'(waited), 32'd0);
        break;
      end
      chk($sformatf("cont%0d_grant", k), 32'(g), 32'(k % 2));
      chk($sformatf("cont%0d_one_ready", k), 32'(req0_ready & req1_ready), 32'd0);
      e.owner = g;
      if (g == 0) begin e.res = 32'h101 + 32'(idx0); e.stat = 4'b0000; end
      else        begin e.res = 32'h1FF + 32'(idx1); e.stat = 4'b0010; end
      sb_q.push_back(e);
      @(posedge clk); #1;
      if (g == 0) begin idx0++; set_req(0, 1'b1, 32'h100 + 32'(idx0), 32'h1, 4'b0010, 1'b0); end
      else        begin idx1++; set_req(1, 1'b1, 32'h200 + 32'(idx1), 32'h1, 4'b0100, 1'b0); end
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("cont%0d_other_valid", k), 32'(rvalid(1 - g)), 32'd0);
      pop_check($sformatf("cont%0d", k));
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, '0, 1'b0);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
